// File: rtl/sync_nff_edge.sv
// Multi-bit level synchronizer with an optional per-channel stability filter.
// It also produces rise, fall and change pulses from the synchronized level.
module sync_nff_edge #(
  parameter int             W        = 1,
  parameter int             STAGES   = 2,
  parameter int             FILT_CYC = 0,
  parameter logic [W-1:0]   RST_VAL  = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  output logic [W-1:0] chg
);

  logic [W-1:0] r_sync [STAGES];
  logic [W-1:0] r_qDly;
  logic [W-1:0] w_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_sync[k] <= RST_VAL;
    end else begin
      r_sync[0] <= d;
      for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[STAGES-1];

  generate
    if (FILT_CYC == 0) begin : gNoFilt
      assign q = w_s;
    end else begin : gFilt
      localparam int            CW   = $clog2(FILT_CYC + 1);
      localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);

      logic [CW-1:0] r_cnt [W];
      logic [W-1:0]  r_q;

      // A channel's count only advances while s disagrees with q; any agreement restarts it.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= RST_VAL;
          for (int i = 0; i < W; i++) r_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < W; i++) begin
            if (w_s[i] == r_q[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == LAST) begin
              r_q[i]   <= w_s[i];
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end
        end
      end

      assign q = r_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_qDly <= RST_VAL;
    else     r_qDly <= q;
  end

  assign rise = q & ~r_qDly;
  assign fall = ~q & r_qDly;
  assign chg  = rise | fall;

endmodule

// File: tb/tb_sync_nff_edge.sv
// Directed and randomized checks of sync_nff_edge across several parameterizations.
// The random section compares against a delay-line plus run-length reference model.
module tb_sync_nff_edge;

  localparam int STAGES_E = 4;
  localparam int FILT_E   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // A: W=4, STAGES=3, no filter
  logic       rstA;
  logic [3:0] dA, qA, riseA, fallA, chgA;
  // B: W=1, STAGES=2, FILT_CYC=4
  logic       rstB;
  logic [0:0] dB, qB, riseB, fallB, chgB;
  // C: W=2, defaults otherwise
  logic       rstC;
  logic [1:0] dC, qC, riseC, fallC, chgC;
  // D: W=4, RST_VAL=4'hF
  logic       rstD;
  logic [3:0] dD, qD, riseD, fallD, chgD;
  // E: W=8, STAGES=4, FILT_CYC=3, randomized
  logic       rstE;
  logic [7:0] dE, qE, riseE, fallE, chgE;

  sync_nff_edge #(.W(4), .STAGES(3), .FILT_CYC(0)) dutA (
    .clk(clk), .rst(rstA), .d(dA), .q(qA), .rise(riseA), .fall(fallA), .chg(chgA));
  sync_nff_edge #(.W(1), .STAGES(2), .FILT_CYC(4)) dutB (
    .clk(clk), .rst(rstB), .d(dB), .q(qB), .rise(riseB), .fall(fallB), .chg(chgB));
  sync_nff_edge #(.W(2)) dutC (
    .clk(clk), .rst(rstC), .d(dC), .q(qC), .rise(riseC), .fall(fallC), .chg(chgC));
  sync_nff_edge #(.W(4), .RST_VAL(4'hF)) dutD (
    .clk(clk), .rst(rstD), .d(dD), .q(qD), .rise(riseD), .fall(fallD), .chg(chgD));
  sync_nff_edge #(.W(8), .STAGES(STAGES_E), .FILT_CYC(FILT_E)) dutE (
    .clk(clk), .rst(rstE), .d(dE), .q(qE), .rise(riseE), .fall(fallE), .chg(chgE));

  // Reference model for E: d delayed STAGES edges, then a per-bit disagreement run length.
  logic [7:0] pipeE [$];
  logic [7:0] qmE;
  int         runE [8];
  logic [7:0] expQE, expRiseE, expFallE;

  task automatic modelReset();
    pipeE.delete();
    for (int k = 0; k < STAGES_E; k++) pipeE.push_back(8'h00);
    qmE = 8'h00;
    for (int b = 0; b < 8; b++) runE[b] = 0;
    expQE = 8'h00; expRiseE = 8'h00; expFallE = 8'h00;
  endtask

  task automatic modelStep(input logic [7:0] dv);
    logic [7:0] sOld, qOld;
    sOld = pipeE.pop_front();
    pipeE.push_back(dv);
    qOld = qmE;
    for (int b = 0; b < 8; b++) begin
      if (sOld[b] != qOld[b]) begin
        runE[b] = runE[b] + 1;
        if (runE[b] == FILT_E) begin
          qmE[b]  = sOld[b];
          runE[b] = 0;
        end
      end else begin
        runE[b] = 0;
      end
    end
    expQE    = qmE;
    expRiseE = qmE & ~qOld;
    expFallE = ~qmE & qOld;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkQuietD(input string tag);
    checkOutput({tag, "_qD"}, 32'(qD), 32'hF);
    checkOutput({tag, "_chgD"}, 32'(chgD), 32'h0);
  endtask

  initial begin
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1; rstD = 1'b1; rstE = 1'b1;
    dA = 4'h0; dB = 1'b0; dC = 2'b00; dD = 4'hF; dE = 8'h00;
    modelReset();
    applyStimulus(2);

    checkOutput("rstA_q", 32'(qA), 32'h0);
    checkOutput("rstA_chg", 32'(chgA), 32'h0);
    checkOutput("rstB_q", 32'(qB), 32'h0);
    checkQuietD("rst");

    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0; rstD = 1'b0; rstE = 1'b0;
    applyStimulus(1);
    checkOutput("relA_chg", 32'(chgA), 32'h0);
    checkOutput("relE_q", 32'(qE), 32'h0);
    checkQuietD("rel");

    // A: three-stage latency, single rise pulse
    dA = 4'hA;
    applyStimulus(1);
    checkOutput("A_e0_q", 32'(qA), 32'h0);
    applyStimulus(1);
    checkOutput("A_e1_q", 32'(qA), 32'h0);
    applyStimulus(1);
    checkOutput("A_e2_q", 32'(qA), 32'hA);
    checkOutput("A_e2_rise", 32'(riseA), 32'hA);
    checkOutput("A_e2_fall", 32'(fallA), 32'h0);
    checkOutput("A_e2_chg", 32'(chgA), 32'hA);
    applyStimulus(1);
    checkOutput("A_e3_q", 32'(qA), 32'hA);
    checkOutput("A_e3_rise", 32'(riseA), 32'h0);

    // B: a 3-cycle glitch must be swallowed
    dB = 1'b1;
    applyStimulus(3);
    dB = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("B_glitch_q%0d", k), 32'(qB), 32'h0);
      checkOutput($sformatf("B_glitch_chg%0d", k), 32'(chgB), 32'h0);
    end

    // B: a held level passes after STAGES+FILT_CYC edges
    dB = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("B_hold_q%0d", k), 32'(qB), 32'h0);
    end
    applyStimulus(1);
    checkOutput("B_e5_q", 32'(qB), 32'h1);
    checkOutput("B_e5_rise", 32'(riseB), 32'h1);
    applyStimulus(1);
    checkOutput("B_e6_rise", 32'(riseB), 32'h0);
    checkOutput("B_e6_q", 32'(qB), 32'h1);

    dB = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("B_low_q%0d", k), 32'(qB), 32'h1);
      checkOutput($sformatf("B_low_fall%0d", k), 32'(fallB), 32'h0);
    end
    applyStimulus(1);
    checkOutput("B_low_e5_q", 32'(qB), 32'h0);
    checkOutput("B_low_e5_fall", 32'(fallB), 32'h1);
    checkOutput("B_low_e5_rise", 32'(riseB), 32'h0);
    applyStimulus(1);
    checkOutput("B_low_e6_fall", 32'(fallB), 32'h0);

    // B: reset in the middle of a filter count
    dB = 1'b1;
    applyStimulus(4);
    checkOutput("B_mid_q", 32'(qB), 32'h0);
    rstB = 1'b1;
    applyStimulus(1);
    checkOutput("B_midrst_q", 32'(qB), 32'h0);
    checkOutput("B_midrst_chg", 32'(chgB), 32'h0);
    rstB = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("B_rel_q%0d", k), 32'(qB), 32'h0);
      checkOutput($sformatf("B_rel_chg%0d", k), 32'(chgB), 32'h0);
    end
    applyStimulus(1);
    checkOutput("B_rel_e5_q", 32'(qB), 32'h1);
    checkOutput("B_rel_e5_rise", 32'(riseB), 32'h1);

    // B: reset while q is high must not produce a fall pulse
    rstB = 1'b1;
    applyStimulus(1);
    checkOutput("B_hirst_q", 32'(qB), 32'h0);
    checkOutput("B_hirst_chg", 32'(chgB), 32'h0);
    rstB = 1'b0;
    dB = 1'b0;
    applyStimulus(1);
    checkOutput("B_hirel_chg", 32'(chgB), 32'h0);

    // C: simultaneous rise and fall on different channels
    dC = 2'b01;
    applyStimulus(3);
    checkOutput("C_pre_q", 32'(qC), 32'h1);
    checkOutput("C_pre_chg", 32'(chgC), 32'h0);
    dC = 2'b10;
    applyStimulus(1);
    checkOutput("C_e0_q", 32'(qC), 32'h1);
    applyStimulus(1);
    checkOutput("C_e1_q", 32'(qC), 32'h2);
    checkOutput("C_e1_rise", 32'(riseC), 32'h2);
    checkOutput("C_e1_fall", 32'(fallC), 32'h1);
    checkOutput("C_e1_chg", 32'(chgC), 32'h3);
    applyStimulus(1);
    checkOutput("C_e2_chg", 32'(chgC), 32'h0);

    checkQuietD("mid");

    // E: randomized activity with a reset burst in the middle
    for (int i = 0; i < 10000; i++) begin
      rstE = (i >= 5000 && i < 5003);
      if ($urandom_range(0, 3) == 0) dE = 8'($urandom);
      applyStimulus(1);
      if (rstE) modelReset();
      else      modelStep(dE);
      checkOutput($sformatf("E_q_%0d", i), 32'(qE), 32'(expQE));
      checkOutput($sformatf("E_rise_%0d", i), 32'(riseE), 32'(expRiseE));
      checkOutput($sformatf("E_fall_%0d", i), 32'(fallE), 32'(expFallE));
      checkOutput($sformatf("E_chg_%0d", i), 32'(chgE), 32'(expRiseE | expFallE));
      if (i % 1000 == 0) checkQuietD($sformatf("rnd%0d", i));
    end
    rstE = 1'b0;

    checkQuietD("end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_nff_edge.md
SYNC_NFF_EDGE -- requirements
Module: sync_nff_edge

Interface
REQ-001 SHALL have parameter W, default 1, channel count (bit width of d and every output); legal range W >= 1.
REQ-002 SHALL have parameter STAGES, default 2, synchronizer flop depth per channel; legal range STAGES >= 2.
REQ-003 SHALL have parameter FILT_CYC, default 0, stability filter length in clk cycles; 0 disables the filter.
REQ-004 SHALL have parameter RST_VAL, default '0, W-bit reset value for every synchronizer stage and for q.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port d  input  W  asynchronous per-channel level inputs.
REQ-008 SHALL have port q  output  W  synchronized, optionally filtered, level.
REQ-009 SHALL have port rise  output  W  one-cycle pulse per channel on a q 0->1 transition.
REQ-010 SHALL have port fall  output  W  one-cycle pulse per channel on a q 1->0 transition.
REQ-011 SHALL have port chg  output  W  per-channel OR of rise and fall.

Function
REQ-012 SHALL implement, per channel, a shift chain sync[1..STAGES]: sync[1] <= d, sync[k] <= sync[k-1]; s = sync[STAGES].
REQ-013 SHALL, with FILT_CYC = 0, drive q = s: a d change present before edge 0 appears on q after edge STAGES-1, i.e. q is valid in the cycle following edge STAGES-1.
REQ-014 SHALL, with FILT_CYC > 0, hold a per-channel counter cnt of width $clog2(FILT_CYC+1) and a q register.
REQ-015 SHALL, with the filter enabled and s[i] == q[i], set cnt[i] <= 0.
REQ-016 SHALL, with the filter enabled, s[i] != q[i] and cnt[i] < FILT_CYC-1, set cnt[i] <= cnt[i]+1.
REQ-017 SHALL, with the filter enabled, s[i] != q[i] and cnt[i] == FILT_CYC-1, set q[i] <= s[i] and cnt[i] <= 0.
REQ-018 SHALL therefore update q only after s has differed from q for FILT_CYC consecutive cycles; total latency is STAGES + FILT_CYC edges.
REQ-019 SHALL discard, with the filter enabled, any s excursion shorter than FILT_CYC cycles: cnt returns to 0 and q is unchanged.
REQ-020 SHALL keep a register q_d <= q each cycle and drive rise = q & ~q_d and fall = ~q & q_d, both combinational from registers.
REQ-021 SHALL assert each rise/fall bit for exactly one cycle per q transition, in the first cycle q shows the new value.
REQ-022 SHALL treat channels fully independently: simultaneous rise on one bit and fall on another are both reported in the same cycle.
REQ-023 SHALL never saturate or wrap cnt beyond FILT_CYC-1.

Reset
REQ-024 SHALL, on rst high at a clk edge, load all sync stages, q, and q_d with RST_VAL and clear every cnt to 0.
REQ-025 SHALL hold rise, fall, and chg at 0 during reset and in the first cycle after release (q == q_d == RST_VAL).
REQ-026 SHALL let rst asserted mid-operation override every pending filter count and in-flight chain value in the same edge.
REQ-027 SHALL produce, after release, transitions only through the normal chain and filter path; when d differs from RST_VAL, the first pulse appears no earlier than STAGES + FILT_CYC edges after release.

Verification
REQ-028 SHALL cover: W=4, STAGES=3, FILT_CYC=0, d steps 0->4'hA before edge 0 -> q=4'hA after edge 2, rise=4'hA for exactly one cycle, fall=0.
REQ-029 SHALL cover: W=1, STAGES=2, FILT_CYC=4, d high for 3 cycles then low -> q stays 0, no pulses; d high for 4+ cycles -> q=1 after edge 5, with rise for one cycle.
REQ-030 SHALL cover: W=2, q=2'b01, d=2'b10 -> rise=2'b10 and fall=2'b01 in the same cycle, chg=2'b11.
REQ-031 SHALL cover: W=4, RST_VAL=4'hF, d=4'hF held through reset release -> q=4'hF, no pulses ever.
REQ-032 SHALL cover: W=1, STAGES=2, FILT_CYC=4, rst asserted while cnt=2 -> q=RST_VAL, cnt=0, no pulse, and the filter count restarts from 0 after release.
REQ-033 SHALL cover: W=8, STAGES=4, random d with a reference model of chain plus filter -> q, rise, fall, and chg match the model every cycle over 10k cycles.
